// File: rtl/aes256_enc_core.sv
// Iterative AES-256 encryption core: one full round per clock, one block per 15 clocks.
// Latency: 14 clocks from the accept edge to the done pulse; ciphertext is registered.
// Backpressure: none; start is taken only in IDLE, ignored while busy, never queued.
//
// Ports:
//   clk        - single clock, rising-edge
//   rst        - synchronous active-high reset
//   start      - encrypt request, accepted only when idle
//   plaintext  - 128-bit input block, sampled on the accept edge only
//   exp_key    - 15 round keys, rk[r] = exp_key[1919-128*r -: 128]; must be held stable
//                from the accept edge through the done cycle
//   ciphertext - result, holds until the next completion or reset
//   busy       - high while rounds 1..14 are in progress
//   done       - one-cycle pulse when ciphertext becomes valid
module aes256_enc_core (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [127:0]  plaintext,
    input  logic [1919:0] exp_key,
    output logic [127:0]  ciphertext,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd14;

    // Forward S-box, byte x lives at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] top;
        top = 11'd2047 - {x, 3'b000};
        return SBOX_TABLE[top -: 8];
    endfunction

    // Multiply by 2 in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        // 3*a = xtime(a) ^ a
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    fsm_t         r_fsm;
    fsm_t         w_fsm_nxt;
    logic [127:0] r_state;
    logic [3:0]   r_round;
    logic [127:0] r_ciphertext;
    logic         r_done;

    logic         w_accept;
    logic         w_last;
    logic [127:0] w_shifted;
    logic [127:0] w_mixed;
    logic [127:0] w_pre_ark;
    logic [127:0] w_rk;
    logic [127:0] w_rk0;
    logic [127:0] w_round_out;

    // SubBytes + ShiftRows: byte (row r, col c) takes the S-box of input byte
    // (row r, col (c+r) mod 4). Bytes are column-major, byte 0 in the MSBs.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_shifted[127-8*(4*c+r) -: 8] =
                sbox(r_state[127-8*(4*((c+r)%4)+r) -: 8]);
        end
        assign w_mixed[127-32*c -: 32] = mix_col(w_shifted[127-32*c -: 32]);
    end

    // Final round skips MixColumns.
    assign w_pre_ark = (r_round == LAST_ROUND) ? w_shifted : w_mixed;

    assign w_rk0 = exp_key[1919 -: 128];

    always_comb begin
        w_rk = '0;
        for (int r = 1; r < 15; r++) begin
            if (r_round == 4'(r)) begin
                w_rk = exp_key[1919-128*r -: 128];
            end
        end
    end

    assign w_round_out = w_pre_ark ^ w_rk;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (start)                  w_fsm_nxt = S_RUN;
            S_RUN:   if (r_round == LAST_ROUND)  w_fsm_nxt = S_IDLE;
            default:                             w_fsm_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_accept   = (r_fsm == S_IDLE) && start;
        w_last     = (r_fsm == S_RUN) && (r_round == LAST_ROUND);
        busy       = (r_fsm == S_RUN);
        done       = r_done;
        ciphertext = r_ciphertext;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= '0;
            r_round      <= '0;
            r_ciphertext <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_state <= plaintext ^ w_rk0;
                r_round <= 4'd1;
            end else if (r_fsm == S_RUN) begin
                r_state <= w_round_out;
                if (w_last) begin
                    r_ciphertext <= w_round_out;
                    r_round      <= 4'd0;
                end else begin
                    r_round <= r_round + 4'd1;
                end
            end
        end
    end

endmodule
